// File: rtl/simon_game_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : simon_game_ctrl_if                                        |
// | Brief    : Bundle of game-control, sequence-generator, display and   |
// |            button signals around the Simon game controller.          |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
interface simon_game_ctrl_if;
  logic        start;
  logic        seq_req;
  logic        seq_valid;
  logic [31:0] seq_in;
  logic        rst_display;
  logic        en_display;
  logic [31:0] seq_in_display;
  logic [3:0]  round_ctr;
  logic        complete_display;
  logic        btn_valid;
  logic [1:0]  btn_colour;
  logic        game_win;
  logic        game_over;
  logic        timeout;

  // Controller side
  modport master (
    input  start, seq_valid, seq_in, complete_display, btn_valid, btn_colour,
    output seq_req, rst_display, en_display, seq_in_display, round_ctr,
           game_win, game_over, timeout
  );

  // Peripheral side (generator, display, buttons, host)
  modport slave (
    output start, seq_valid, seq_in, complete_display, btn_valid, btn_colour,
    input  seq_req, rst_display, en_display, seq_in_display, round_ctr,
           game_win, game_over, timeout
  );
endinterface
`default_nettype wire

// File: rtl/simon_game_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : simon_game_ctrl                                           |
// | Brief    : Simon game controller. Fetches a 16-colour sequence,      |
// |            drives the display for N+1 colours per round, checks      |
// |            player presses and reports win / game over.               |
// |            Optional macro SIMON_INPUT_TIMEOUT_EN adds an inactivity  |
// |            timeout while waiting for button presses.                 |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module simon_game_ctrl #(
  parameter int MAX_ROUND      = 15,
  parameter int GAP_CYCLES     = 5_000_000,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  wire logic         clk,
  input  wire logic         rst,
  simon_game_ctrl_if.master bus
);

  localparam int         c_GAP_W     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(GAP_CYCLES - 1);
  localparam [3:0]       c_MAX_ROUND = 4'(MAX_ROUND);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_DISP_RST = 3'd2,
    S_DISPLAY  = 3'd3,
    S_INPUT    = 3'd4,
    S_GAP      = 3'd5,
    S_WIN      = 3'd6,
    S_LOSE     = 3'd7
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [31:0]        r_seq, w_seq_nxt;
  logic [3:0]         r_round, w_round_nxt;
  logic [3:0]         r_in_idx, w_in_idx_nxt;
  logic [c_GAP_W-1:0] r_gap_cnt, w_gap_nxt;
  logic               w_seq_req_nxt;
  logic               w_to_fire;
  logic [1:0]         w_exp_colour;

  logic r_seq_req, r_rst_disp, r_en_disp, r_win, r_over, r_timeout;

`ifdef SIMON_INPUT_TIMEOUT_EN
  localparam int          c_TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYCLES - 1);
  logic [c_TO_W-1:0]      r_to_cnt;

  // Inactivity counter: held at zero outside INPUT and restarted by every press
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_to_cnt <= '0;
    else if (r_state != S_INPUT || bus.btn_valid)
      r_to_cnt <= '0;
    else if (r_to_cnt != c_TO_LAST)
      r_to_cnt <= r_to_cnt + c_TO_W'(1);
  end

  // A press arriving in the expiry cycle wins over the timeout
  assign w_to_fire = (r_state == S_INPUT) && !bus.btn_valid && (r_to_cnt == c_TO_LAST);
`else
  logic [31:0] w_unused_timeout_cycles;
  assign w_unused_timeout_cycles = 32'(TIMEOUT_CYCLES);
  assign w_to_fire = 1'b0;
`endif

  assign w_exp_colour = r_seq[{r_in_idx, 1'b0} +: 2];

  // Next-state and datapath update decisions
  always_comb begin
    w_state_nxt   = r_state;
    w_seq_nxt     = r_seq;
    w_round_nxt   = r_round;
    w_in_idx_nxt  = r_in_idx;
    w_gap_nxt     = r_gap_cnt;
    w_seq_req_nxt = 1'b0;
    case (r_state)
      S_IDLE, S_WIN, S_LOSE: begin
        if (bus.start) begin
          w_seq_req_nxt = 1'b1;
          w_state_nxt   = S_LOAD;
        end
      end
      S_LOAD: begin
        if (bus.seq_valid) begin
          w_seq_nxt   = bus.seq_in;
          w_round_nxt = '0;
          w_state_nxt = S_DISP_RST;
        end
      end
      S_DISP_RST: w_state_nxt = S_DISPLAY;
      S_DISPLAY: begin
        if (bus.complete_display) begin
          w_in_idx_nxt = '0;
          w_state_nxt  = S_INPUT;
        end
      end
      S_INPUT: begin
        if (bus.btn_valid) begin
          if (bus.btn_colour != w_exp_colour)
            w_state_nxt = S_LOSE;
          else if (r_in_idx < r_round)
            w_in_idx_nxt = r_in_idx + 4'd1;
          else if (r_round == c_MAX_ROUND)
            w_state_nxt = S_WIN;
          else begin
            w_round_nxt = r_round + 4'd1;
            w_gap_nxt   = '0;
            w_state_nxt = S_GAP;
          end
        end else if (w_to_fire) begin
          w_state_nxt = S_LOSE;
        end
      end
      S_GAP: begin
        if (r_gap_cnt == c_GAP_LAST)
          w_state_nxt = S_DISP_RST;
        else
          w_gap_nxt = r_gap_cnt + c_GAP_W'(1);
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, datapath and registered outputs (outputs decoded from next state)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_seq      <= '0;
      r_round    <= '0;
      r_in_idx   <= '0;
      r_gap_cnt  <= '0;
      r_seq_req  <= 1'b0;
      r_rst_disp <= 1'b0;
      r_en_disp  <= 1'b0;
      r_win      <= 1'b0;
      r_over     <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_seq      <= w_seq_nxt;
      r_round    <= w_round_nxt;
      r_in_idx   <= w_in_idx_nxt;
      r_gap_cnt  <= w_gap_nxt;
      r_seq_req  <= w_seq_req_nxt;
      r_rst_disp <= (w_state_nxt == S_DISP_RST);
      r_en_disp  <= (w_state_nxt == S_DISPLAY);
      r_win      <= (w_state_nxt == S_WIN);
      r_over     <= (w_state_nxt == S_LOSE);
      // Timeout flag is captured on entry to LOSE and held while there
      r_timeout  <= (w_state_nxt == S_LOSE) ?
                    ((r_state == S_LOSE) ? r_timeout : w_to_fire) : 1'b0;
    end
  end

  assign bus.seq_req        = r_seq_req;
  assign bus.rst_display    = r_rst_disp;
  assign bus.en_display     = r_en_disp;
  assign bus.seq_in_display = r_seq;
  assign bus.round_ctr      = r_round;
  assign bus.game_win       = r_win;
  assign bus.game_over      = r_over;
  assign bus.timeout        = r_timeout;

endmodule
`default_nettype wire

// File: doc/simon_game_ctrl.md
SIMON_GAME_CTRL -- requirements
Module: simon_game_ctrl

Interface
REQ-001 Parameter MAX_ROUND, default 15, final round index (1..15); clearing it wins the game.
REQ-002 Parameter GAP_CYCLES, default 5_000_000, idle clk ticks between a cleared round and the next display.
REQ-003 Parameter TIMEOUT_CYCLES, default 50_000_000, max clk ticks allowed between button presses (only with SIMON_INPUT_TIMEOUT_EN).
REQ-004 clk  input  1  single clock; all logic on posedge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  1-cycle pulse: begin new game.
REQ-007 seq_req  output  1  1-cycle pulse: request a new 16-colour sequence from the generator.
REQ-008 seq_valid  input  1  generator has a sequence on seq_in.
REQ-009 seq_in  input  32  16 colours, 2 bits each, LSB-first.
REQ-010 rst_display  output  1  synchronous reset to the display block.
REQ-011 en_display  output  1  enable to the display block.
REQ-012 seq_in_display  output  32  latched sequence driven to the display block.
REQ-013 round_ctr  output  4  current round N; display shows N+1 colours.
REQ-014 complete_display  input  1  display finished (sticky until rst_display).
REQ-015 btn_valid  input  1  1-cycle pulse: player pressed a button (already debounced).
REQ-016 btn_colour  input  2  colour of the pressed button.
REQ-017 game_win  output  1  high while in WIN.
REQ-018 game_over  output  1  high while in LOSE.
REQ-019 timeout  output  1  high while in LOSE if entered by timeout.

Function
REQ-020 States: IDLE, LOAD, DISP_RST, DISPLAY, INPUT, GAP, WIN, LOSE.
- All outputs registered.
- rst_display = (state==DISP_RST); en_display = (state==DISPLAY).
REQ-021 IDLE/WIN/LOSE: start -> seq_req pulse for 1 cycle, go LOAD; start is ignored in every other state.
REQ-022 LOAD: seq_valid -> latch seq_in into seq_in_display, round_ctr<=0, go DISP_RST; seq_valid outside LOAD is ignored.
REQ-023 DISP_RST: exactly 1 cycle, then DISPLAY.
REQ-024 DISPLAY: en_display held high; complete_display=1 -> in_idx<=0, go INPUT; btn_valid ignored.
REQ-025 INPUT: on btn_valid, compare btn_colour with seq_in_display[2*in_idx +: 2] in the same cycle:
- mismatch -> LOSE;
- match, in_idx<round_ctr -> in_idx+1;
- match, in_idx==round_ctr, round_ctr==MAX_ROUND -> WIN;
- otherwise round_ctr+1, go GAP.
REQ-026 GAP: count GAP_CYCLES ticks (counter cleared on entry), then DISP_RST; btn_valid ignored.
REQ-027 in_idx is 4 bits; round_ctr never exceeds MAX_ROUND and never wraps.
REQ-028 Counter widths are $clog2 of their parameter, minimum 1 bit.
REQ-029 WIN/LOSE hold round_ctr (score) until the next start.

Reset
REQ-030 rst asserted: state=IDLE; seq_in_display, round_ctr, in_idx and all counters cleared; every output 0 — including mid-game and mid-display.
REQ-031 Deassertion: first transition possible on the first posedge with rst low.

Configuration
REQ-032 Macro SIMON_INPUT_TIMEOUT_EN.
- Defined: in INPUT, a counter clears on entry and on each accepted press; reaching TIMEOUT_CYCLES-1 with no btn_valid -> LOSE with timeout=1.
- A btn_valid in that same cycle takes priority over the timeout.
- Undefined: no counter, INPUT waits indefinitely, timeout tied 0.

Verification
REQ-033 Bench parameters: MAX_ROUND=2, GAP_CYCLES=4, TIMEOUT_CYCLES=20.
REQ-034 start, seq_valid with seq_in=0x0000_00E4 -> seq_req 1 cycle, rst_display 1 cycle, en_display high until complete_display, round_ctr=0.
REQ-035 Round 0 press colour 0 -> GAP 4 cycles, round_ctr=1, rst_display pulse, en_display.
REQ-036 Round 1 press 0 then 2 (expected 1) -> game_over=1, timeout=0, round_ctr=1.
REQ-037 Correct presses through round 2 (0; 0,1; 0,1,2) -> game_win=1, round_ctr=2; then start -> seq_req, LOAD.
REQ-038 SIMON_INPUT_TIMEOUT_EN defined, no press for 20 cycles in INPUT -> game_over=1, timeout=1; undefined -> still in INPUT after 1000 cycles.
REQ-039 rst pulsed during DISPLAY -> all outputs 0 immediately; start during DISPLAY -> ignored.
